// File: rtl/fetch_ctrl.sv
// fetch_ctrl: stall-aware, redirect-safe instruction fetch sequencer.
// One outstanding imem request; a redirect kills the stale in-flight fetch.
module fetch_ctrl #(
  parameter int ADDR_W = 10,
  parameter int OFF_W = 21,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              id_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_base,
  input  logic [OFF_W-1:0]  redirect_offset,
  output logic              misalign_err
);
  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, tgt, if_pc_n;
  logic [31:0] if_instr_n;
  logic kill, kill_n, if_valid_n, unused_off;
  // Offset bits above ADDR_W vanish in the mod-2^ADDR_W sum, so sign extension is moot.
  assign unused_off = ^redirect_offset[OFF_W-1:ADDR_W];
  assign tgt = redirect_base + redirect_offset[ADDR_W-1:0];
  always_comb begin
    state_n = state;
    pc_n = pc;
    kill_n = kill;
    if_valid_n = if_valid;
    if_instr_n = if_instr;
    if_pc_n = if_pc;
    case (state)
      S_FETCH: if (imem_req && imem_gnt) begin
        state_n = S_WAIT;
        kill_n = redirect;
      end
      S_WAIT: if (imem_rvalid) begin
        kill_n = 1'b0;
        state_n = (kill || redirect) ? S_FETCH : S_HOLD;
        if (!kill && !redirect) begin
          if_valid_n = 1'b1;
          if_instr_n = imem_rdata;
          if_pc_n = pc;
          pc_n = pc + ADDR_W'(4);
        end
      end else kill_n = kill || redirect;
      default: if (redirect || id_ready) begin
        state_n = S_FETCH;
        if_valid_n = 1'b0;
      end
    endcase
    if (redirect) pc_n = {tgt[ADDR_W-1:2], 2'b00};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      pc <= RESET_PC;
      kill <= 1'b0;
      imem_req <= 1'b0;
      imem_addr <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc <= '0;
      misalign_err <= 1'b0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      kill <= kill_n;
      imem_req <= state_n == S_FETCH;
      imem_addr <= pc_n;
      if_valid <= if_valid_n;
      if_instr <= if_instr_n;
      if_pc <= if_pc_n;
      misalign_err <= redirect && |tgt[1:0];
    end
  end
endmodule
